// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - packs a qualified serial bit stream into WIDTH-bit words behind a 2-entry buffer
module serial_word_packer #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0,
    localparam int CW       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_bit_valid,
    input  logic             i_bit,
    input  logic             i_flush,
    input  logic             i_clear_overflow,
    input  logic             i_word_ready,
    output logic [WIDTH-1:0] o_word,
    output logic [CW-1:0]    o_word_bits,
    output logic             o_word_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_overflow
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} buf_state_t;

    buf_state_t       r_state;
    logic [WIDTH-1:0] r_sr;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_head_word;
    logic [CW-1:0]    r_head_bits;
    logic [WIDTH-1:0] r_tail_word;
    logic [CW-1:0]    r_tail_bits;
    logic             r_valid;
    logic             r_overflow;

    logic [WIDTH-1:0] w_sr_shift;
    logic [CW-1:0]    w_n;
    logic [CW-1:0]    w_shamt;
    logic             w_full;
    logic             w_partial;
    logic             w_push;
    logic             w_pop;
    logic             w_drop;
    logic [WIDTH-1:0] w_new_word;
    logic [CW-1:0]    w_new_bits;

    always_comb begin
        w_sr_shift = r_sr;
        if (i_bit_valid) begin
            w_sr_shift = LSB_FIRST ? {i_bit, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], i_bit};
        end
        w_n       = r_cnt + CW'(i_bit_valid);
        w_full    = i_bit_valid && (r_cnt == CW'(WIDTH - 1));
        // Flush sees the count after this cycle's bit; a completing bit already emits the word.
        w_partial = !w_full && i_flush && (w_n != '0);
        w_push    = w_full || w_partial;
        w_shamt   = CW'(WIDTH) - w_n;
        if (w_full) begin
            w_new_word = w_sr_shift;
            w_new_bits = CW'(WIDTH);
        end else begin
            w_new_word = LSB_FIRST ? (w_sr_shift >> w_shamt) : (w_sr_shift << w_shamt);
            w_new_bits = w_n;
        end
        w_pop  = r_valid && i_word_ready;
        w_drop = (r_state == S_TWO) && w_push && !w_pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_push) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else begin
            r_sr  <= w_sr_shift;
            r_cnt <= w_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_head_word <= '0;
            r_head_bits <= '0;
            r_tail_word <= '0;
            r_tail_bits <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_word <= w_new_word;
                        r_head_bits <= w_new_bits;
                        r_valid     <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_word <= w_new_word;
                        r_head_bits <= w_new_bits;
                    end else if (w_push) begin
                        r_tail_word <= w_new_word;
                        r_tail_bits <= w_new_bits;
                        r_state     <= S_TWO;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_word <= r_tail_word;
                        r_head_bits <= r_tail_bits;
                        if (w_push) begin
                            r_tail_word <= w_new_word;
                            r_tail_bits <= w_new_bits;
                        end else begin
                            r_state <= S_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= S_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_word       = r_head_word;
    assign o_word_bits  = r_head_bits;
    assign o_word_valid = r_valid;
    assign o_count      = r_cnt;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - table, directed and random checks of serial_word_packer in both bit orders
module tb_serial_word_packer;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_bit_valid = 1'b0;
    logic          i_bit = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_clear_overflow = 1'b0;
    logic          i_word_ready = 1'b0;
    logic [W-1:0]  o_word0, o_word1;
    logic [CW-1:0] o_bits0, o_bits1, o_count0, o_count1;
    logic          o_valid0, o_valid1, o_ovf0, o_ovf1;

    serial_word_packer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst_n(rst_n), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
        .i_flush(i_flush), .i_clear_overflow(i_clear_overflow), .i_word_ready(i_word_ready),
        .o_word(o_word0), .o_word_bits(o_bits0), .o_word_valid(o_valid0),
        .o_count(o_count0), .o_overflow(o_ovf0)
    );

    serial_word_packer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst_n(rst_n), .i_bit_valid(i_bit_valid), .i_bit(i_bit),
        .i_flush(i_flush), .i_clear_overflow(i_clear_overflow), .i_word_ready(i_word_ready),
        .o_word(o_word1), .o_word_bits(o_bits1), .o_word_valid(o_valid1),
        .o_count(o_count1), .o_overflow(o_ovf1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: pending bits and buffered words as plain lists; word value from bit positions.
    typedef struct {
        logic [31:0] w_msb;
        logic [31:0] w_lsb;
        int          bits;
    } mword_t;

    bit     pend[$];
    mword_t mq[$];
    bit     m_ovf = 1'b0;

    typedef struct {
        bit          v;
        bit          b;
        bit          f;
        bit          rdy;
        bit          e_valid;
        int          e_count;
        logic [7:0]  e_word;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mword_t form_word();
        mword_t m;
        m.w_msb = '0;
        m.w_lsb = '0;
        m.bits  = pend.size();
        for (int i = 0; i < pend.size(); i++) begin
            m.w_msb[W-1-i] = pend[i];
            m.w_lsb[i]     = pend[i];
        end
        return m;
    endfunction

    task automatic model_reset();
        pend.delete();
        mq.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit b, input bit f, input bit c, input bit r);
        bit     pop;
        bit     push;
        int     pre;
        mword_t nw;
        pop  = (mq.size() > 0) && r;
        pre  = mq.size();
        push = 1'b0;
        if (v) pend.push_back(b);
        if (pend.size() == W || (f && pend.size() > 0)) begin
            nw   = form_word();
            push = 1'b1;
            pend.delete();
        end
        if (pop) void'(mq.pop_front());
        if (push && pre == 2 && !pop) m_ovf = 1'b1;
        else begin
            if (push) mq.push_back(nw);
            if (c) m_ovf = 1'b0;
        end
    endtask

    task automatic check_model();
        chk("model valid msb", 32'(o_valid0), 32'(mq.size() > 0));
        chk("model valid lsb", 32'(o_valid1), 32'(mq.size() > 0));
        chk("model count msb", 32'(o_count0), 32'(pend.size()));
        chk("model count lsb", 32'(o_count1), 32'(pend.size()));
        chk("model ovf msb", 32'(o_ovf0), 32'(m_ovf));
        chk("model ovf lsb", 32'(o_ovf1), 32'(m_ovf));
        if (mq.size() > 0) begin
            chk("model word msb", 32'(o_word0), mq[0].w_msb);
            chk("model word lsb", 32'(o_word1), mq[0].w_lsb);
            chk("model bits msb", 32'(o_bits0), 32'(mq[0].bits));
            chk("model bits lsb", 32'(o_bits1), 32'(mq[0].bits));
        end
    endtask

    task automatic cycle(input bit v, input bit b, input bit f, input bit c, input bit r);
        @(negedge clk);
        i_bit_valid      = v;
        i_bit            = b;
        i_flush          = f;
        i_clear_overflow = c;
        i_word_ready     = r;
        @(posedge clk);
        model_step(v, b, f, c, r);
        #1;
        check_model();
    endtask

    // MSB of data is sent first; ready/clear are raised only with the final bit.
    task automatic send_byte(input logic [7:0] data, input bit rdy_last, input bit clr_last);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, data[7-i], 1'b0, (i == 7) && clr_last, (i == 7) && rdy_last);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " word"},  32'({o_word0, o_word1}), 32'd0);
        chk({tag, " bits"},  32'({o_bits0, o_bits1}), 32'd0);
        chk({tag, " valid"}, 32'({o_valid0, o_valid1}), 32'd0);
        chk({tag, " count"}, 32'({o_count0, o_count1}), 32'd0);
        chk({tag, " ovf"},   32'({o_ovf0, o_ovf1}), 32'd0);
    endtask

    initial begin
        tbl[0] = '{1, 1, 0, 1, 0, 1, 8'h00};
        tbl[1] = '{1, 0, 0, 1, 0, 2, 8'h00};
        tbl[2] = '{1, 1, 0, 1, 0, 3, 8'h00};
        tbl[3] = '{1, 1, 0, 1, 0, 4, 8'h00};
        tbl[4] = '{1, 0, 0, 1, 0, 5, 8'h00};
        tbl[5] = '{1, 0, 0, 1, 0, 6, 8'h00};
        tbl[6] = '{1, 1, 0, 1, 0, 7, 8'h00};
        tbl[7] = '{1, 0, 0, 1, 1, 0, 8'hB2};
        tbl[8] = '{0, 0, 0, 1, 0, 0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Full word, MSB first, consumer always ready
        for (int k = 0; k < 9; k++) begin
            cycle(tbl[k].v, tbl[k].b, tbl[k].f, 1'b0, tbl[k].rdy);
            chk($sformatf("tbl%0d valid", k), 32'(o_valid0), 32'(tbl[k].e_valid));
            chk($sformatf("tbl%0d count", k), 32'(o_count0), 32'(tbl[k].e_count));
            if (tbl[k].e_valid) begin
                chk($sformatf("tbl%0d word", k), 32'(o_word0), 32'(tbl[k].e_word));
                chk($sformatf("tbl%0d bits", k), 32'(o_bits0), 32'd8);
                chk($sformatf("tbl%0d lsb word", k), 32'(o_word1), 32'h4D);
            end
        end

        // Partial flush: LSB-first right-aligned, MSB-first left-aligned
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        cycle(0, 0, 1, 0, 1);
        chk("flush lsb word", 32'(o_word1), 32'h03);
        chk("flush lsb bits", 32'(o_bits1), 32'd3);
        chk("flush msb word", 32'(o_word0), 32'hC0);
        cycle(0, 0, 1, 0, 1);
        chk("empty flush valid", 32'(o_valid1), 32'd0);

        // Backpressure then overflow on the third word
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        chk("ovf set", 32'(o_ovf0), 32'd1);
        chk("ovf head", 32'(o_word0), 32'h11);
        cycle(0, 0, 0, 0, 1);
        chk("pop second", 32'(o_word0), 32'h22);
        cycle(0, 0, 0, 0, 1);
        chk("drained", 32'(o_valid0), 32'd0);
        chk("ovf sticky", 32'(o_ovf0), 32'd1);
        cycle(0, 0, 0, 1, 0);
        chk("ovf cleared", 32'(o_ovf0), 32'd0);

        // Set wins over clear in the same cycle
        send_byte(8'hA5, 0, 0);
        send_byte(8'h5A, 0, 0);
        send_byte(8'hFF, 0, 1);
        chk("set beats clear", 32'(o_ovf0), 32'd1);
        cycle(0, 0, 0, 1, 0);
        chk("clear next", 32'(o_ovf0), 32'd0);

        // Push with pop while full keeps order and drops nothing
        send_byte(8'h3C, 1, 0);
        chk("pushpop ovf", 32'(o_ovf0), 32'd0);
        chk("pushpop head", 32'(o_word0), 32'h5A);
        cycle(0, 0, 0, 0, 1);
        chk("pushpop tail", 32'(o_word0), 32'h3C);
        cycle(0, 0, 0, 0, 1);

        // Asynchronous reset mid-word with a word buffered
        send_byte(8'h77, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1'(i & 1), 0, 0, 0);
        @(negedge clk);
        i_bit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        send_byte(8'h96, 0, 0);
        chk("post reset word", 32'(o_word0), 32'h96);
        chk("post reset bits", 32'(o_bits0), 32'd8);
        chk("post reset ovf", 32'(o_ovf0), 32'd0);
        cycle(0, 0, 0, 0, 1);

        // Random traffic against the reference
        for (int k = 0; k < 800; k++) begin
            cycle($urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(19, 0) == 0,
                  $urandom_range(19, 0) == 0, 1'($urandom));
        end

        // Full-rate throughput with ready held high
        for (int k = 0; k < 64; k++) cycle(1, 1'($urandom), 0, 0, 1);
        chk("throughput ovf", 32'(o_ovf0), 32'(m_ovf));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
